// File: rtl/freq_scan_ctrl.sv
// Round-robin period meter: scans NCH square-wave inputs and reports one period per channel.
// Optional macro FREQ_SCAN_AVG_EN: each result is the truncated mean of four consecutive periods.
module freq_scan_ctrl #(
   parameter int          NCH     = 4,
   parameter int          CW      = 16,
   parameter int unsigned TIMEOUT = 16'hFFFF,
   parameter int          SETTLE  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           cont,
   input  logic [NCH-1:0] freq_in,
   output logic           busy,
   output logic [2:0]     chan_sel,
   output logic [CW-1:0]  period,
   output logic [2:0]     period_chan,
   output logic           period_valid,
   output logic           timeout,
   output logic [2:0]     dbg_state
);

   // Handshake: start is a level sampled only in IDLE; cont is sampled only in the
   // REPORT cycle of the last channel; period_valid is a one-cycle pulse, no back-pressure.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ARM     = 3'd2,
      ST_MEASURE = 3'd3,
      ST_REPORT  = 3'd4
   } state_t;

   localparam logic [CW:0] TO_LIM      = (CW+1)'(TIMEOUT);
   localparam logic [CW:0] INC1        = (CW+1)'(1);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [2:0]  LAST_CH     = 3'(NCH - 1);

   state_t         state_q, state_d;
   logic [2:0]     chan_q, chan_d;
   logic [3:0]     settle_q, settle_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  period_q, period_d;
   logic [2:0]     pchan_q, pchan_d;
   logic           to_q, to_d;

   logic [NCH-1:0] sync1_q, sync2_q, prev_q;
   logic [NCH-1:0] rise_vec;
   logic [7:0]     rise_pad;
   logic           sel_rise;
   logic [CW:0]    cnt_inc;
   logic           to_hit;
   logic [CW-1:0]  cnt_sat;

`ifdef FREQ_SCAN_AVG_EN
   logic [CW+1:0]  acc_q, acc_d;
   logic [1:0]     pidx_q, pidx_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= freq_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Only the selected channel's edge is ever looked at; SETTLE ignores it so an
   // edge that straddles a channel switch never reaches ARM.
   assign rise_vec = sync2_q & ~prev_q;
   assign rise_pad = 8'(rise_vec);
   assign sel_rise = rise_pad[chan_q];

   // Elapsed cycles including the current one; abort when it reaches TIMEOUT.
   assign cnt_inc = {1'b0, cnt_q} + INC1;
   assign to_hit  = (cnt_inc >= TO_LIM);
   assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[CW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         chan_q   <= '0;
         settle_q <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         pchan_q  <= '0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pchan_q  <= pchan_d;
         to_q     <= to_d;
      end
   end

`ifdef FREQ_SCAN_AVG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         pidx_q <= '0;
      end else begin
         acc_q  <= acc_d;
         pidx_q <= pidx_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      settle_d = settle_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      pchan_d  = pchan_q;
      to_d     = to_q;
`ifdef FREQ_SCAN_AVG_EN
      acc_d    = acc_q;
      pidx_d   = pidx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_SETTLE;
               chan_d   = '0;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            settle_d = settle_q + 4'd1;
            if (settle_q == SETTLE_LAST) begin
               state_d = ST_ARM;
               cnt_d   = '0;
            end
         end
         ST_ARM: begin
            if (sel_rise) begin
               state_d = ST_MEASURE;
               cnt_d   = '0;
`ifdef FREQ_SCAN_AVG_EN
               acc_d   = '0;
               pidx_d  = '0;
`endif
            end else if (to_hit) begin
               state_d  = ST_REPORT;
               period_d = '0;
               to_d     = 1'b1;
               pchan_d  = chan_q;
            end else begin
               cnt_d = cnt_sat;
            end
         end
         ST_MEASURE: begin
            // Edge has priority over abort on the TIMEOUT cycle.
            if (sel_rise) begin
               cnt_d = '0;
`ifdef FREQ_SCAN_AVG_EN
               acc_d  = acc_q + {1'b0, cnt_inc};
               pidx_d = pidx_q + 2'd1;
               if (pidx_q == 2'd3) begin
                  state_d  = ST_REPORT;
                  period_d = acc_d[CW+1:2];
                  to_d     = 1'b0;
                  pchan_d  = chan_q;
               end
`else
               state_d  = ST_REPORT;
               period_d = cnt_inc[CW-1:0];
               to_d     = 1'b0;
               pchan_d  = chan_q;
`endif
            end else if (to_hit) begin
               state_d  = ST_REPORT;
               period_d = '0;
               to_d     = 1'b1;
               pchan_d  = chan_q;
            end else begin
               cnt_d = cnt_sat;
            end
         end
         ST_REPORT: begin
            settle_d = '0;
            if (chan_q == LAST_CH) begin
               chan_d  = '0;
               state_d = cont ? ST_SETTLE : ST_IDLE;
            end else begin
               chan_d  = chan_q + 3'd1;
               state_d = ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy         = (state_q != ST_IDLE);
   assign chan_sel     = chan_q;
   assign period       = period_q;
   assign period_chan  = pchan_q;
   assign timeout      = to_q;
   assign period_valid = (state_q == ST_REPORT);
   assign dbg_state    = state_q;

endmodule

// File: doc/freq_scan_ctrl.md
FREQ_SCAN_CTRL -- requirements
Module: freq_scan_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of frequency input channels, 2..8.
REQ-002 Parameter CW, default 16: period count width in bits.
REQ-003 Parameter TIMEOUT, default 16'hFFFF: cycle limit for waiting on an edge, 1..2^CW-1.
REQ-004 Parameter SETTLE, default 4: dead cycles after each channel switch, 1..15.
REQ-005 clk  in  1  single system clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  level; sampled in IDLE, begins one scan of all channels.
REQ-008 cont  in  1  level; sampled at end of each scan, 1 = rescan from channel 0.
REQ-009 freq_in  in  NCH  raw asynchronous square-wave inputs.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 chan_sel  out  3  channel currently measured.
REQ-012 period  out  CW  last measured period in clk cycles.
REQ-013 period_chan  out  3  channel that produced period.
REQ-014 period_valid  out  1  one-cycle pulse when period/period_chan/timeout update.
REQ-015 timeout  out  1  1 = last result aborted, no edge within TIMEOUT.

Function
REQ-016 Each freq_in bit SHALL pass a 2-flop synchronizer; rising edge = sync high and previous sync low.
REQ-017 States SHALL be IDLE, SETTLE, ARM, MEASURE, REPORT.
REQ-018 IDLE: start=1 -> SETTLE with chan_sel=0; start while busy SHALL be ignored.
REQ-019 SETTLE: edge history cleared; after SETTLE cycles -> ARM; cycle counter cleared.
REQ-020 ARM: first rising edge on chan_sel -> MEASURE, counter cleared; counter reaching TIMEOUT -> REPORT with timeout=1.
REQ-021 MEASURE: counter increments every cycle; each rising edge ends one period; period value = cycles between consecutive rising edges (edges at t0 and t1 give t1-t0).
REQ-022 MEASURE: counter reaching TIMEOUT without an edge -> REPORT with timeout=1, period=0.
REQ-023 After required periods complete -> REPORT with timeout=0.
REQ-024 REPORT: one cycle; period_valid=1, period_chan=chan_sel; then chan_sel+1 -> SETTLE, or after channel NCH-1: cont=1 -> SETTLE channel 0, cont=0 -> IDLE.
REQ-025 An edge coinciding with the TIMEOUT cycle SHALL count as an edge, not a timeout.
REQ-026 period, period_chan, timeout SHALL hold between period_valid pulses.
REQ-027 Counter SHALL never wrap; saturating comparison against TIMEOUT governs abort.
REQ-028 Edges on non-selected channels SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, chan_sel=0, period=0, period_chan=0, period_valid=0, timeout=0, counters and synchronizers 0.
REQ-030 Reset mid-measurement SHALL discard the partial result; no period_valid pulse emitted.
REQ-031 After rst_n rises, block SHALL stay in IDLE until start sampled high.

Configuration
REQ-032 Macro FREQ_SCAN_AVG_EN defined: MEASURE covers 4 consecutive periods, summed in CW+2 bits, period = sum>>2 (truncated); timeout applies per period.
REQ-033 Macro FREQ_SCAN_AVG_EN undefined: MEASURE covers exactly 1 period; no accumulator logic built.

Verification
REQ-034 freq_in[0] period 100 clk, others idle, start pulse, cont=0 -> period_valid with period_chan=0, period=100, timeout=0; channels 1..3 report timeout=1, period=0; then busy=0.
REQ-035 Channels 0..3 periods 50/80/120/200 clk, cont=1 -> results 50,80,120,200 in channel order, repeating from channel 0.
REQ-036 TIMEOUT=300, channel 2 period 400 -> channel 2 reports timeout=1, period=0; channel 3 unaffected.
REQ-037 FREQ_SCAN_AVG_EN defined, channel 0 periods 99,101,100,102 -> period=100; undefined -> period=99.
REQ-038 rst_n low during MEASURE on channel 1 -> all outputs 0 within the reset, no period_valid; start after release -> scan restarts at channel 0.
REQ-039 start held high during a scan, cont=0 -> exactly one scan, then IDLE for one cycle before next scan begins.
